// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel-strobe phase, h/v counters, and a one-pixel
// registered output stage carrying syncs, blanking and gated colour to the DAC.
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rgb_r,
  input  logic [7:0] rgb_g,
  input  logic [7:0] rgb_b,
  output logic [9:0] h_counter,
  output logic [9:0] v_counter,
  output logic       pix_en,
  output logic       active,
  output logic       frame_start,
  output logic       vga_clk,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  logic       phase_q;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       h_wrap, v_wrap;
  logic       hs_region, vs_region;
  logic       fs_q;
  logic       hs_q, vs_q, blank_n_q;
  logic [7:0] r_q, g_q, b_q;

  assign h_wrap    = (h_q == H_LAST);
  assign v_wrap    = (v_q == V_LAST);
  assign active    = (h_q < H_VIS) && (v_q < V_VIS);
  assign hs_region = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
  assign vs_region = (v_q >= VS_FIRST) && (v_q <= VS_LAST);

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_wrap) begin
      h_d = 10'd0;
      v_d = v_wrap ? 10'd0 : v_q + 10'd1;
    end
  end

  // Counters and the output stage advance only on strobe edges (phase_q high).
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q   <= 1'b0;
      h_q       <= 10'd0;
      v_q       <= 10'd0;
      fs_q      <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      r_q       <= 8'd0;
      g_q       <= 8'd0;
      b_q       <= 8'd0;
    end else begin
      phase_q <= ~phase_q;
      fs_q    <= phase_q && h_wrap && v_wrap;
      if (phase_q) begin
        h_q       <= h_d;
        v_q       <= v_d;
        hs_q      <= ~hs_region;
        vs_q      <= ~vs_region;
        blank_n_q <= active;
        r_q       <= active ? rgb_r : 8'd0;
        g_q       <= active ? rgb_g : 8'd0;
        b_q       <= active ? rgb_b : 8'd0;
      end
    end
  end

  assign h_counter   = h_q;
  assign v_counter   = v_q;
  assign pix_en      = phase_q;
  assign vga_clk     = phase_q;
  assign frame_start = fs_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: full horizontal timing, shortened vertical
// frame (10 lines) so whole-frame behaviour fits in a short run.
module tb_vga_timing;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rgb_r, rgb_g, rgb_b;
  logic [9:0] h_counter, v_counter;
  logic       pix_en, active, frame_start, vga_clk;
  logic       vga_hs, vga_vs, vga_blank_n;
  logic [7:0] vga_r, vga_g, vga_b;

  vga_timing #(
    .H_ACTIVE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_ACTIVE(4),   .V_FRONT(2),  .V_SYNC(2),  .V_BACK(2)
  ) dut (
    .clk(clk), .reset(reset),
    .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
    .h_counter(h_counter), .v_counter(v_counter),
    .pix_en(pix_en), .active(active), .frame_start(frame_start),
    .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_low = 0;
  int vs_low = 0;
  int fs_cnt = 0;
  int blank_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clk edge, then observe on the falling edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (!vga_hs) hs_low++;
    if (!vga_vs) vs_low++;
    if (frame_start) fs_cnt++;
    if (!vga_blank_n && (vga_r != 8'd0 || vga_g != 8'd0 || vga_b != 8'd0)) blank_bad++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic clear_stats();
    cyc = 0; hs_low = 0; vs_low = 0; fs_cnt = 0; blank_bad = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_h"}, 32'(h_counter), 32'd0);
    check({tag, "_v"}, 32'(v_counter), 32'd0);
    check({tag, "_pix"}, 32'(pix_en), 32'd0);
    check({tag, "_fs"}, 32'(frame_start), 32'd0);
    check({tag, "_hs"}, 32'(vga_hs), 32'd1);
    check({tag, "_vs"}, 32'(vga_vs), 32'd1);
    check({tag, "_blank"}, 32'(vga_blank_n), 32'd0);
    check({tag, "_rgb"}, {8'd0, vga_r, vga_g, vga_b}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    rgb_r = 8'hFF; rgb_g = 8'hFF; rgb_b = 8'h00;
    @(negedge clk);
    tick(); tick(); tick();
    check_reset_state("rst");

    reset = 1'b0;
    clear_stats();
    tick();
    check("n1_pix", 32'(pix_en), 32'd1);
    check("n1_vgaclk", 32'(vga_clk), 32'd1);
    check("n1_h", 32'(h_counter), 32'd0);
    check("n1_r", 32'(vga_r), 32'd0);
    tick();
    check("n2_pix", 32'(pix_en), 32'd0);
    check("n2_h", 32'(h_counter), 32'd1);
    check("n2_rgb", {8'd0, vga_r, vga_g, vga_b}, 32'h00FFFF00);
    check("n2_blank", 32'(vga_blank_n), 32'd1);

    // Right edge of visible area, one pixel lag on the outputs.
    run_to(1280);
    check("n1280_h", 32'(h_counter), 32'd640);
    check("n1280_active", 32'(active), 32'd0);
    check("n1280_r", 32'(vga_r), 32'hFF);
    run_to(1282);
    check("n1282_blank", 32'(vga_blank_n), 32'd0);
    check("n1282_rgb", {8'd0, vga_r, vga_g, vga_b}, 32'd0);

    run_to(1313);
    check("hs_pre_h", 32'(h_counter), 32'd656);
    check("hs_pre", 32'(vga_hs), 32'd1);
    run_to(1314);
    check("hs_start", 32'(vga_hs), 32'd0);
    run_to(1504);
    check("hs_tail", 32'(vga_hs), 32'd0);
    run_to(1506);
    check("hs_end", 32'(vga_hs), 32'd1);

    run_to(1599);
    check("n1599_h", 32'(h_counter), 32'd799);
    check("n1599_v", 32'(v_counter), 32'd0);
    run_to(1600);
    check("n1600_h", 32'(h_counter), 32'd0);
    check("n1600_v", 32'(v_counter), 32'd1);
    check("line_hs_low", 32'(hs_low), 32'd192);

    // Colour changes between strobes must not reach the outputs.
    run_to(1602);
    check("tog_pre", {8'd0, vga_r, vga_g, vga_b}, 32'h00FFFF00);
    rgb_r = 8'hAA; rgb_g = 8'hBB; rgb_b = 8'hCC;
    tick();
    check("tog_hold", {8'd0, vga_r, vga_g, vga_b}, 32'h00FFFF00);
    rgb_r = 8'h11; rgb_g = 8'h22; rgb_b = 8'h33;
    tick();
    check("tog_latch", {8'd0, vga_r, vga_g, vga_b}, 32'h00112233);
    rgb_r = 8'hFF; rgb_g = 8'hFF; rgb_b = 8'h00;

    run_to(9601);
    check("vs_pre", 32'(vga_vs), 32'd1);
    run_to(9602);
    check("vs_start", 32'(vga_vs), 32'd0);
    check("fs_none_yet", 32'(fs_cnt), 32'd0);
    run_to(15999);
    check("n15999_fs", 32'(frame_start), 32'd0);
    run_to(16000);
    check("wrap_h", 32'(h_counter), 32'd0);
    check("wrap_v", 32'(v_counter), 32'd0);
    check("wrap_fs", 32'(frame_start), 32'd1);
    run_to(16001);
    check("fs_one_clk", 32'(frame_start), 32'd0);
    check("frame_fs_cnt", 32'(fs_cnt), 32'd1);
    check("frame_vs_low", 32'(vs_low), 32'd3200);
    check("blank_rgb_zero", 32'(blank_bad), 32'd0);

    // Mid-frame reset.
    run_to(21400);
    check("mid_h", 32'(h_counter), 32'd300);
    check("mid_v", 32'(v_counter), 32'd3);
    reset = 1'b1;
    tick(); tick(); tick();
    check_reset_state("midrst");
    reset = 1'b0;
    clear_stats();
    tick();
    check("rel_n1_pix", 32'(pix_en), 32'd1);
    check("rel_n1_h", 32'(h_counter), 32'd0);
    tick();
    check("rel_n2_h", 32'(h_counter), 32'd1);
    check("rel_n2_v", 32'(v_counter), 32'd0);
    check("rel_n2_r", 32'(vga_r), 32'hFF);
    check("rel_no_fs", 32'(fs_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
